// File: rtl/distance_filter.sv
// Smoothed, rate-controlled distance reading: samples distance_in every SAMPLE_DIV clocks and publishes a 2**LOG2_WIN moving average.
// Optional hysteresis proximity alarm on the average is compiled in with `define DISTANCE_FILTER_ALARM_EN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_WAIT    | idle until the tick counter wraps, then latch distance_in
// ST_ACCUM   | fold latched sample into running sum / circular buffer
// ST_PUBLISH | register new average, pulse avg_valid, update primed/near
module distance_filter #(
    parameter int          LOG2_WIN   = 2,
    parameter int          SAMPLE_DIV = 100,
    parameter logic [7:0]  NEAR_ON    = 8'd20,
    parameter logic [7:0]  NEAR_OFF   = 8'd30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] distance_in,
    output logic [7:0] distance_avg,
    output logic       avg_valid,
    output logic       primed,
    output logic       near
);

    localparam int W      = 1 << LOG2_WIN;
    localparam int SUM_W  = 8 + LOG2_WIN;
    localparam int PTR_W  = (LOG2_WIN > 0) ? LOG2_WIN : 1;
    localparam int FILL_W = LOG2_WIN + 1;
    localparam int CNT_W  = $clog2(SAMPLE_DIV);

    if (SAMPLE_DIV < 4) begin : g_bad_div
        $error("distance_filter: SAMPLE_DIV must be >= 4");
    end
    if (NEAR_ON >= NEAR_OFF) begin : g_bad_near
        $error("distance_filter: NEAR_ON must be below NEAR_OFF");
    end

    typedef enum logic [1:0] {ST_WAIT, ST_ACCUM, ST_PUBLISH} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                tick_end;
    logic [7:0]          sample;
    logic [7:0]          buf_mem [W];
    logic [SUM_W-1:0]    sum;
    logic [PTR_W-1:0]    wptr;
    logic [FILL_W-1:0]   fill;
    logic                fill_full;
    logic [7:0]          avg_next;

    assign tick_end  = (cnt == CNT_W'(SAMPLE_DIV - 1));
    assign fill_full = (fill == FILL_W'(W));
    assign avg_next  = 8'(sum >> LOG2_WIN);

    // Free-running sample timer, independent of FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (tick_end)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_WAIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT:    if (tick_end) state_nxt = ST_ACCUM;
            ST_ACCUM:   state_nxt = ST_PUBLISH;
            ST_PUBLISH: state_nxt = ST_WAIT;
            default:    state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample       <= '0;
            sum          <= '0;
            wptr         <= '0;
            fill         <= '0;
            distance_avg <= '0;
            avg_valid    <= 1'b0;
            primed       <= 1'b0;
            for (int i = 0; i < W; i++)
                buf_mem[i] <= '0;
        end else begin
            avg_valid <= 1'b0;
            case (state)
                ST_WAIT: begin
                    if (tick_end)
                        sample <= distance_in;
                end
                ST_ACCUM: begin
                    // Sum never exceeds 255*W, so no overflow guard is needed.
                    sum           <= sum + SUM_W'(sample) - SUM_W'(buf_mem[wptr]);
                    buf_mem[wptr] <= sample;
                    wptr          <= (wptr == PTR_W'(W - 1)) ? '0 : wptr + 1'b1;
                    if (!fill_full)
                        fill <= fill + 1'b1;
                end
                ST_PUBLISH: begin
                    distance_avg <= avg_next;
                    avg_valid    <= 1'b1;
                    primed       <= fill_full;
                end
                default: ;
            endcase
        end
    end

`ifdef DISTANCE_FILTER_ALARM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            near <= 1'b0;
        else if (state == ST_PUBLISH) begin
            if (!fill_full)
                near <= 1'b0;
            else if (avg_next <= NEAR_ON)
                near <= 1'b1;
            else if (avg_next >= NEAR_OFF)
                near <= 1'b0;
        end
    end
`else
    assign near = 1'b0;
`endif

endmodule

// File: tb/tb_distance_filter.sv
// Randomized self-checking bench for distance_filter against a sliding-window reference model.
module tb_distance_filter;

    localparam int LOG2_WIN   = 2;
    localparam int W          = 4;
    localparam int SAMPLE_DIV = 100;
    localparam int NEAR_ON    = 20;
    localparam int NEAR_OFF   = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] distance_in = 8'd0;
    logic [7:0] distance_avg;
    logic       avg_valid;
    logic       primed;
    logic       near;

    always #5 clk = ~clk;

    distance_filter #(
        .LOG2_WIN   (LOG2_WIN),
        .SAMPLE_DIV (SAMPLE_DIV),
        .NEAR_ON    (8'(NEAR_ON)),
        .NEAR_OFF   (8'(NEAR_OFF))
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .distance_in  (distance_in),
        .distance_avg (distance_avg),
        .avg_valid    (avg_valid),
        .primed       (primed),
        .near         (near)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: edges since release, last W samples, sample count.
    int edge_n;
    int win[$];
    int nsamp;
    int exp_avg;
    bit exp_valid;
    bit exp_primed;
    bit exp_near;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, edge_n, $time);
        end
    endtask

    function automatic void model_clear();
        edge_n = 0;
        win.delete();
        for (int i = 0; i < W; i++) win.push_back(0);
        nsamp      = 0;
        exp_avg    = 0;
        exp_valid  = 1'b0;
        exp_primed = 1'b0;
        exp_near   = 1'b0;
    endfunction

    function automatic void model_edge(input int din);
        int s;
        edge_n++;
        exp_valid = 1'b0;
        if (edge_n >= SAMPLE_DIV + 2 && (edge_n - 2) % SAMPLE_DIV == 0) begin
            s = 0;
            foreach (win[i]) s += win[i];
            exp_avg    = s / W;
            exp_valid  = 1'b1;
            exp_primed = (nsamp >= W);
`ifdef DISTANCE_FILTER_ALARM_EN
            if (!exp_primed)
                exp_near = 1'b0;
            else if (exp_avg <= NEAR_ON)
                exp_near = 1'b1;
            else if (exp_avg >= NEAR_OFF)
                exp_near = 1'b0;
`else
            exp_near = 1'b0;
`endif
        end
        if (edge_n % SAMPLE_DIV == 0) begin
            win.push_back(din);
            void'(win.pop_front());
            nsamp++;
        end
    endfunction

    task automatic check_outputs(input string pfx);
        check_val({pfx, "_avg_valid"},    int'(avg_valid),    int'(exp_valid));
        check_val({pfx, "_distance_avg"}, int'(distance_avg), exp_avg);
        check_val({pfx, "_primed"},       int'(primed),       int'(exp_primed));
        check_val({pfx, "_near"},         int'(near),         int'(exp_near));
    endtask

    task automatic step();
        int din;
        din = int'(distance_in);
        @(posedge clk);
        #1;
        if (!reset)
            model_clear();
        else
            model_edge(din);
        check_outputs("cyc");
    endtask

    // Drives n sample periods; the sampled value sits on the sampling edge,
    // other cycles carry random junk that the filter must ignore.
    task automatic run_samples(input int n, input bit rnd, input int val);
        int v;
        for (int s = 0; s < n; s++) begin
            if (rnd)
                v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 60));
            else
                v = val;
            for (int c = 0; c < SAMPLE_DIV; c++) begin
                if ((edge_n + 1) % SAMPLE_DIV == 0)
                    distance_in = 8'(v);
                else
                    distance_in = 8'($urandom_range(0, 255));
                step();
            end
        end
    endtask

    initial begin
        model_clear();
        reset = 1'b0;
        repeat (10) step();
        reset = 1'b1;

        run_samples(4, 1'b0, 40);
        run_samples(4, 1'b0, 0);
        run_samples(3, 1'b0, 40);
        run_samples(12, 1'b0, 255);
        run_samples(1, 1'b0, 40);

        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        run_samples(3, 1'b0, 40);
        reset = 1'b0;
        #1;
        model_clear();
        check_outputs("rst_imm");
        repeat (5) step();
        reset = 1'b1;
        run_samples(5, 1'b0, 40);

        run_samples(24, 1'b1, 0);
        distance_in = 8'd0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
